// File: rtl/cla_pkg.sv
// Shared constants and vector types for the 4-bit carry look-ahead adder.
// Imported by the adder RTL and by its testbench.
package cla_pkg;

    localparam int CLA_W = 4;

    typedef logic [CLA_W-1:0] operand_t;
    // Carry vector indexed [CLA_W:1]: element i is the carry out of bit i-1.
    typedef logic [CLA_W:1]   carry_t;

endpackage

// File: rtl/cla_carry_gen.sv
// Flat two-level carry look-ahead network for four bits.
// Every carry is a sum of products of p, g and c0; there is no ripple chain.
module cla_carry_gen
    import cla_pkg::*;
(
    input  logic [CLA_W-1:0] p,
    input  logic [CLA_W-1:0] g,
    input  logic             c0,
    output carry_t           c
);

    // Each term is written out in full so that no carry depends on another.
    always_comb begin
        c[1] = g[0]
             | (p[0] & c0);
        c[2] = g[1]
             | (p[1] & g[0])
             | (p[1] & p[0] & c0);
        c[3] = g[2]
             | (p[2] & g[1])
             | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3]
             | (p[3] & g[2])
             | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
    end

endmodule

// File: rtl/carry_look_ahead_adder_4bit.sv
// Registered 4-bit carry look-ahead adder with one cycle of latency.
// Define CLA_OVF_EN to add the registered signed-overflow output ovf.
module carry_look_ahead_adder_4bit
    import cla_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [CLA_W-1:0] a,
    input  logic [CLA_W-1:0] b,
    input  logic             cin,
    output logic [CLA_W-1:0] sum,
    output logic [CLA_W:1]   c_out,
`ifdef CLA_OVF_EN
    output logic             ovf,
`endif
    output logic             out_valid
);

    operand_t p;
    operand_t g;
    carry_t   c_gen;
    operand_t c_in_bit;
    operand_t sum_next;

    operand_t sum_reg;
    carry_t   c_out_reg;
    logic     out_valid_reg;

    // Carry into each bit: cin for bit 0, look-ahead carries above it.
    assign c_in_bit = {c_gen[CLA_W-1:1], cin};

    generate
        for (genvar gi = 0; gi < CLA_W; gi++) begin : g_bit
            assign g[gi]        = a[gi] & b[gi];
            assign p[gi]        = a[gi] ^ b[gi];
            assign sum_next[gi] = p[gi] ^ c_in_bit[gi];
        end
    endgenerate

    cla_carry_gen u_carry_gen (
        .p  (p),
        .g  (g),
        .c0 (cin),
        .c  (c_gen)
    );

    // Results load only on accepted cycles, so idle operands never reach the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_reg       <= '0;
            c_out_reg     <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= in_valid;
            if (in_valid) begin
                sum_reg   <= sum_next;
                c_out_reg <= c_gen;
            end
        end
    end

`ifdef CLA_OVF_EN
    logic ovf_reg;

    // Signed overflow: carry into the sign bit differs from the carry out of it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (in_valid) begin
            ovf_reg <= c_gen[CLA_W] ^ c_gen[CLA_W-1];
        end
    end

    assign ovf = ovf_reg;
`endif

    assign sum       = sum_reg;
    assign c_out     = c_out_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_carry_look_ahead_adder_4bit.sv
// Self-checking bench for carry_look_ahead_adder_4bit: directed steps, exhaustive
// sweep and random traffic against an arithmetic reference model.
module tb_carry_look_ahead_adder_4bit;
    import cla_pkg::*;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic [3:0]     a;
    logic [3:0]     b;
    logic           cin;
    logic [3:0]     sum;
    carry_t         c_out;
    logic           out_valid;
`ifdef CLA_OVF_EN
    logic           ovf;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: what the outputs should show after the last edge.
    logic [3:0] m_sum;
    logic [4:1] m_c;
    logic       m_valid;
    logic       m_ovf;

    always #5 clk = ~clk;

    carry_look_ahead_adder_4bit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sum       (sum),
        .c_out     (c_out),
`ifdef CLA_OVF_EN
        .ovf       (ovf),
`endif
        .out_valid (out_valid)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Model update from plain integer arithmetic on the operands.
    task automatic model(input logic [3:0] va, input logic [3:0] vb, input logic vc,
                         input logic vv, input logic vr);
        int total;
        int part;
        int sa;
        int sb;
        if (vr) begin
            m_sum = '0; m_c = '0; m_valid = 1'b0; m_ovf = 1'b0;
        end else if (vv) begin
            total = int'(va) + int'(vb) + int'(vc);
            m_sum = total[3:0];
            for (int i = 1; i <= 4; i++) begin
                part = (int'(va) % (1 << i)) + (int'(vb) % (1 << i)) + int'(vc);
                m_c[i] = ((part >> i) & 1) == 1;
            end
            sa = va[3] ? int'(va) - 16 : int'(va);
            sb = vb[3] ? int'(vb) - 16 : int'(vb);
            m_ovf = (sa + sb + int'(vc) > 7) || (sa + sb + int'(vc) < -8);
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
    endtask

    // One transaction: drive on the falling edge, check 1 time unit after the rising edge.
    task automatic step(input string tag, input logic [3:0] va, input logic [3:0] vb,
                        input logic vc, input logic vv, input logic vr);
        @(negedge clk);
        rst = vr; in_valid = vv; a = va; b = vb; cin = vc;
        @(posedge clk);
        #1;
        model(va, vb, vc, vv, vr);
        $display("%s rst=%b v=%b a=%b b=%b cin=%b -> sum=%b c_out=%b out_valid=%b",
                 tag, vr, vv, va, vb, vc, sum, c_out, out_valid);
        chk({tag, ".sum"},   {4'b0, sum},   {4'b0, m_sum});
        chk({tag, ".c_out"}, {4'b0, c_out}, {4'b0, m_c});
        chk({tag, ".valid"}, {7'b0, out_valid}, {7'b0, m_valid});
`ifdef CLA_OVF_EN
        chk({tag, ".ovf"},   {7'b0, ovf},   {7'b0, m_ovf});
`endif
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; a = 4'hF; b = 4'hF; cin = 1'b0;

        // Reset held with a valid operation pending: it must be discarded.
        step("reset0", 4'hF, 4'hF, 1'b0, 1'b1, 1'b1);
        step("reset1", 4'hF, 4'hF, 1'b0, 1'b1, 1'b1);
        chk("reset.sum_const", {4'b0, sum}, 8'h00);

        step("add7p10", 4'b0111, 4'b1010, 1'b0, 1'b1, 1'b0);
        chk("add7p10.sum_const", {4'b0, sum}, 8'b0000_0001);
        chk("add7p10.c_const", {4'b0, c_out}, 8'b0000_1110);

        step("ff_ff", 4'b1111, 4'b1111, 1'b0, 1'b1, 1'b0);
        chk("ff_ff.sum_const", {4'b0, sum}, 8'b0000_1110);
        step("f_1_c", 4'b1111, 4'b0001, 1'b1, 1'b1, 1'b0);
        chk("f_1_c.c_const", {4'b0, c_out}, 8'b0000_1111);

        // Back-to-back stream, one result per cycle.
        step("strm0", 4'b0001, 4'b0100, 1'b0, 1'b1, 1'b0);
        step("strm1", 4'b0110, 4'b1000, 1'b0, 1'b1, 1'b0);
        step("strm2", 4'b1001, 4'b0110, 1'b0, 1'b1, 1'b0);
        chk("strm2.sum_const", {4'b0, sum}, 8'b0000_1111);

        // Idle cycles with changing and unknown operands: outputs hold.
        step("idle0", 4'b1010, 4'b0101, 1'b1, 1'b0, 1'b0);
        step("idle1", 4'bxxxx, 4'bxxxx, 1'bx, 1'b0, 1'b0);
        step("idle2", 4'b0011, 4'b1100, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a stream.
        step("strm3", 4'b0101, 4'b0101, 1'b1, 1'b1, 1'b0);
        step("midrst", 4'b1111, 4'b1110, 1'b1, 1'b1, 1'b1);
        step("postrst", 4'b0010, 4'b0011, 1'b0, 1'b1, 1'b0);

        // Exhaustive sweep of every operand/carry combination.
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            step("exh", v[3:0], v[7:4], v[8], 1'b1, 1'b0);
        end

        // Random traffic with occasional idle cycles and resets.
        for (int i = 0; i < 200; i++) begin
            step("rnd", 4'($urandom), 4'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/carry_look_ahead_adder_4bit.md
CARRY_LOOK_AHEAD_ADDER_4BIT -- requirements
Module: carry_look_ahead_adder_4bit

Interface
REQ-001 Parameters: none; operand width is fixed at 4 bits by the package constant CLA_W = 4.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  operands valid this cycle; capture enable.
REQ-006 a  in  4  addend A, unsigned (also read as two's complement for ovf).
REQ-007 b  in  4  addend B.
REQ-008 cin  in  1  carry into bit 0.
REQ-009 sum  out  4  registered sum bits.
REQ-010 c_out  out  4, indexed [4:1]  registered per-bit carries; c_out[i] is the carry out of bit i-1; c_out[4] is the final carry.
REQ-011 out_valid  out  1  sum/c_out hold a result captured on the previous accepted cycle.
REQ-012 ovf  out  1  signed overflow; present only with CLA_OVF_EN.

Function
REQ-013 Per bit i in 0..3: g_i = a_i AND b_i; p_i = a_i XOR b_i; c_0 = cin.
REQ-014 Carries come from flat lookahead, with no ripple chain: c1 = g0|p0c0; c2 = g1|p1g0|p1p0c0; c3 = g2|p2g1|p2p1g0|p2p1p0c0; c4 = g3|p3g2|p3p2g1|p3p2p1g0|p3p2p1p0c0.
REQ-015 sum_i = p_i XOR c_i; {c_out[4], sum} always equals a + b + cin (5-bit exact, no truncation).
REQ-016 Latency is 1 cycle: operands sampled on a rising edge with in_valid=1 appear on sum/c_out after that edge.
REQ-017 On an edge with in_valid=1 and rst=0: sum, c_out and ovf load the new results and out_valid is set to 1.
REQ-018 On an edge with in_valid=0 and rst=0: sum, c_out and ovf hold their values and out_valid is cleared to 0.
REQ-019 Back-to-back in_valid yields one result per cycle with no bubbles.
REQ-020 Wrap-around: a result of 16 or more sets c_out[4]=1 and sum = (a+b+cin) mod 16.
REQ-021 Unknown or X operands while in_valid=0 do not affect outputs.

Reset
REQ-022 When rst=1 at a rising edge: sum=0000, c_out=0000, out_valid=0 and ovf=0, regardless of in_valid.
REQ-023 rst has priority over in_valid; an operation in flight during reset is discarded with no output.
REQ-024 The first accepted operation after rst deasserts produces out_valid=1 one cycle later.

Configuration
REQ-025 Macro CLA_OVF_EN defined: port ovf exists and is registered with sum; ovf = c4 XOR c3.
REQ-026 CLA_OVF_EN undefined: port ovf and its register are absent, and all other behaviour is identical.

Structure
REQ-027 Package cla_pkg holds CLA_W = 4 and the operand/carry vector typedefs shared by the DUT and the bench.
REQ-028 Combinational sub-module cla_carry_gen:
- inputs: p[3:0], g[3:0], c0;
- outputs: c[4:1];
- implements REQ-014.
REQ-029 The top module computes p/g, instantiates cla_carry_gen, forms sum and holds the output registers.

Verification
REQ-030 rst=1 for 2 cycles with in_valid=1, a=1111, b=1111 -> sum=0000, c_out=0000, out_valid=0.
REQ-031 a=0111, b=1010, cin=0, in_valid=1 -> next cycle sum=0001, c_out=1110, out_valid=1; ovf=0 if CLA_OVF_EN.
REQ-032 a=1111, b=1111, cin=0 -> sum=1110, c_out=1111; a=1111, b=0001, cin=1 -> sum=0001, c_out=1111.
REQ-033 Stream a=0001/b=0100, then a=0110/b=1000, then a=1001/b=0110 (cin=0, in_valid=1 each cycle) -> sums 0101, 1110, 1111 on consecutive cycles, c_out[4]=0 for all.
REQ-034 in_valid=0 with changing a/b -> outputs hold and out_valid=0; rst mid-stream -> outputs 0 on the next edge.
REQ-035 Exhaustive 512 combinations of a/b/cin -> {c_out[4], sum} == a+b+cin; each c_out[i] matches its reference carry; ovf matches the signed overflow check when enabled.
